// File: rtl/asm_status_datapath_if.sv
// Controller <-> datapath bus for the 8-state ASM pair: decoded state and
// operands flow toward the datapath, status flags and observation outputs flow back.
interface asm_status_datapath_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [7:0]       dec_in;
  logic             x;
  logic             y;
  logic             F;
  logic             E;
  logic [WIDTH-1:0] a_out;
  logic [CNT_W-1:0] cnt_out;
  logic             done;
  logic             onehot_err;

  modport master (
    output start, data_in, dec_in,
    input  x, y, F, E, a_out, cnt_out, done, onehot_err
  );

  modport slave (
    input  start, data_in, dec_in,
    output x, y, F, E, a_out, cnt_out, done, onehot_err
  );
endinterface

// File: rtl/asm_status_datapath.sv
// Datapath half of the 8-state ASM pair: executes the micro-ops of the
// one-hot state on dec_in and returns x/y/F/E status to the controller.
module asm_status_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  asm_status_datapath_if.slave bus
);

  logic [WIDTH-1:0] a_q;
  logic [CNT_W-1:0] cnt_q;
  logic             x_q;
  logic             e_q;
  logic             f_q;
  logic             done_q;
  logic             err_q;
  logic             dec_valid;

  assign dec_valid = $onehot(bus.dec_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      cnt_q  <= '0;
      x_q    <= 1'b0;
      e_q    <= 1'b0;
      f_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (!dec_valid) begin
      // Malformed state word: freeze datapath, drop pulses, latch the error.
      err_q  <= 1'b1;
      x_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= bus.dec_in[0] & bus.start;
      done_q <= bus.dec_in[3] | bus.dec_in[7];
      unique case (1'b1)
        bus.dec_in[0]: begin
          if (bus.start) begin
            a_q   <= bus.data_in;
            cnt_q <= '0;
            e_q   <= 1'b0;
            f_q   <= 1'b0;
          end
        end
        bus.dec_in[1]: begin
          a_q   <= a_q + 1'b1;
          cnt_q <= cnt_q + 1'b1;
        end
        bus.dec_in[2]: begin
          e_q <= a_q[WIDTH-1];
          f_q <= (a_q[1:0] == 2'b11);
        end
        bus.dec_in[3]: a_q <= a_q >> 1;
        bus.dec_in[4]: begin
          a_q   <= a_q << 1;
          cnt_q <= cnt_q + 1'b1;
        end
        bus.dec_in[5]: a_q <= ~a_q;
        bus.dec_in[6]: cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = &cnt_q;
  assign bus.F          = f_q;
  assign bus.E          = e_q;
  assign bus.a_out      = a_q;
  assign bus.cnt_out    = cnt_q;
  assign bus.done       = done_q;
  assign bus.onehot_err = err_q;

endmodule

// File: tb/tb_asm_status_datapath.sv
// Directed bench for asm_status_datapath: each state's micro-op, flag timing,
// counter wrap, one-hot error stickiness and mid-operation reset.
module tb_asm_status_datapath;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  asm_status_datapath_if #(.WIDTH(8), .CNT_W(4)) bus ();

  asm_status_datapath #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one state word for one clock edge, then settle past the edge.
  task automatic cyc(input logic [7:0] dec, input logic st, input logic [7:0] din);
    bus.dec_in  = dec;
    bus.start   = st;
    bus.data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cyc(8'h01, 1'b1, 8'hAA);
    cyc(8'h01, 1'b1, 8'hAA);
    check_eq("rst_a",    32'(bus.a_out), 32'h00);
    check_eq("rst_cnt",  32'(bus.cnt_out), 32'h0);
    check_eq("rst_x",    32'(bus.x), 32'h0);
    check_eq("rst_y",    32'(bus.y), 32'h0);
    check_eq("rst_f",    32'(bus.F), 32'h0);
    check_eq("rst_e",    32'(bus.E), 32'h0);
    check_eq("rst_done", 32'(bus.done), 32'h0);
    check_eq("rst_err",  32'(bus.onehot_err), 32'h0);
    rst = 1'b0;

    // Load and flags
    cyc(8'h01, 1'b1, 8'hFE);
    check_eq("ld_a", 32'(bus.a_out), 32'hFE);
    check_eq("ld_x", 32'(bus.x), 32'h1);
    cyc(8'h02, 1'b1, 8'h00);
    check_eq("s1_a",   32'(bus.a_out), 32'hFF);
    check_eq("s1_cnt", 32'(bus.cnt_out), 32'h1);
    check_eq("s1_x",   32'(bus.x), 32'h0);
    cyc(8'h04, 1'b0, 8'h00);
    check_eq("s2_e", 32'(bus.E), 32'h1);
    check_eq("s2_f", 32'(bus.F), 32'h1);
    cyc(8'h08, 1'b0, 8'h00);
    check_eq("s3_a",    32'(bus.a_out), 32'h7F);
    check_eq("s3_done", 32'(bus.done), 32'h1);
    cyc(8'h40, 1'b0, 8'h00);
    check_eq("s3_done_drop", 32'(bus.done), 32'h0);
    check_eq("s6_cnt",       32'(bus.cnt_out), 32'h2);

    // Counter wrap
    cyc(8'h01, 1'b1, 8'hFF);
    check_eq("ld2_cnt", 32'(bus.cnt_out), 32'h0);
    check_eq("ld2_ef",  32'({bus.E, bus.F}), 32'h0);
    for (int i = 0; i < 15; i++) cyc(8'h40, 1'b0, 8'h00);
    check_eq("wrap_cnt15", 32'(bus.cnt_out), 32'hF);
    check_eq("wrap_y1",    32'(bus.y), 32'h1);
    cyc(8'h02, 1'b0, 8'h00);
    check_eq("wrap_a",    32'(bus.a_out), 32'h00);
    check_eq("wrap_cnt0", 32'(bus.cnt_out), 32'h0);
    check_eq("wrap_y0",   32'(bus.y), 32'h0);

    // Back-to-back S7 holds done for two cycles
    cyc(8'h80, 1'b0, 8'h00);
    check_eq("s7_done1", 32'(bus.done), 32'h1);
    cyc(8'h80, 1'b0, 8'h00);
    check_eq("s7_done2", 32'(bus.done), 32'h1);
    cyc(8'h20, 1'b0, 8'h00);
    check_eq("s7_done_drop", 32'(bus.done), 32'h0);
    check_eq("s5_inv0",      32'(bus.a_out), 32'hFF);

    // Shift and invert
    cyc(8'h01, 1'b1, 8'h81);
    cyc(8'h10, 1'b0, 8'h00);
    check_eq("s4_a",   32'(bus.a_out), 32'h02);
    check_eq("s4_cnt", 32'(bus.cnt_out), 32'h1);
    cyc(8'h20, 1'b0, 8'h00);
    check_eq("s5_a", 32'(bus.a_out), 32'hFD);
    cyc(8'h04, 1'b0, 8'h00);
    check_eq("s2b_e", 32'(bus.E), 32'h1);
    check_eq("s2b_f", 32'(bus.F), 32'h0);

    // One-hot error is sticky and freezes the datapath
    cyc(8'h03, 1'b1, 8'h55);
    check_eq("oh2_err", 32'(bus.onehot_err), 32'h1);
    check_eq("oh2_a",   32'(bus.a_out), 32'hFD);
    check_eq("oh2_cnt", 32'(bus.cnt_out), 32'h1);
    check_eq("oh2_x",   32'(bus.x), 32'h0);
    cyc(8'h00, 1'b0, 8'h00);
    check_eq("oh0_err", 32'(bus.onehot_err), 32'h1);
    check_eq("oh0_a",   32'(bus.a_out), 32'hFD);
    check_eq("oh0_cnt", 32'(bus.cnt_out), 32'h1);
    cyc(8'h02, 1'b0, 8'h00);
    check_eq("oh_sticky", 32'(bus.onehot_err), 32'h1);
    check_eq("oh_s1_a",   32'(bus.a_out), 32'hFE);
    check_eq("oh_s1_cnt", 32'(bus.cnt_out), 32'h2);

    // Reset mid-operation wins over the S1 increment
    cyc(8'h01, 1'b1, 8'h10);
    check_eq("ld3_a", 32'(bus.a_out), 32'h10);
    cyc(8'h80, 1'b0, 8'h00);
    check_eq("pre_rst_done", 32'(bus.done), 32'h1);
    rst = 1'b1;
    cyc(8'h02, 1'b0, 8'h00);
    rst = 1'b0;
    check_eq("mid_rst_a",    32'(bus.a_out), 32'h00);
    check_eq("mid_rst_cnt",  32'(bus.cnt_out), 32'h0);
    check_eq("mid_rst_done", 32'(bus.done), 32'h0);
    check_eq("mid_rst_err",  32'(bus.onehot_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
